// File: rtl/line_buffer_pkg.sv
// Shared types and width helpers for the line-buffer row sequencer.
package line_buffer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOP_PAD,
        S_ROW,
        S_GAP,
        S_BOT_PAD,
        S_DONE
    } seq_state_e;

    localparam int unsigned MIN_CNT_W = 1;

    // Bits needed to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? MIN_CNT_W : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/line_buffer_row_sequencer.sv
// Emits one padded frame (top pad rows, data rows, bottom pad rows) as a column
// strobe stream with a fixed idle gap and a row_complete pulse after every row.
module line_buffer_row_sequencer
    import line_buffer_pkg::*;
#(
    parameter int unsigned KER_SIZE    = 3,
    parameter int unsigned INPUT_X_DIM = 3,
    parameter int unsigned INPUT_Y_DIM = 3,
    parameter int unsigned PAD         = 1,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ROW_GAP     = KER_SIZE + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_pad,
    output logic              row_complete,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned COL_W = cnt_w(INPUT_X_DIM - 1);
    localparam int unsigned ROW_W = cnt_w(2 * PAD + INPUT_Y_DIM);
    localparam int unsigned GAP_W = cnt_w(ROW_GAP - 1);

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(INPUT_X_DIM - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(ROW_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_RC     = GAP_W'(ROW_GAP - 2);
    localparam logic [ROW_W-1:0] R_TOP_END  = ROW_W'(PAD);
    localparam logic [ROW_W-1:0] R_DATA_END = ROW_W'(PAD + INPUT_Y_DIM);
    localparam logic [ROW_W-1:0] R_BOT_END  = ROW_W'(2 * PAD + INPUT_Y_DIM);

    if (ROW_GAP < 2) begin : g_bad_row_gap
        $error("ROW_GAP must be at least 2");
    end

    seq_state_e        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d, row_inc;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic              pad_row, accept;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_pad_q, out_pad_d;
    logic              row_complete_q, row_complete_d;
    logic              frame_done_q, frame_done_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            col_q          <= '0;
            row_q          <= '0;
            gap_q          <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_pad_q      <= 1'b0;
            row_complete_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            gap_q          <= gap_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_pad_q      <= out_pad_d;
            row_complete_q <= row_complete_d;
            frame_done_q   <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        gap_d   = gap_q;
        row_inc = row_q + ROW_W'(1);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    col_d   = '0;
                    row_d   = '0;
                    gap_d   = '0;
                    state_d = (PAD > 0) ? S_TOP_PAD : S_ROW;
                end
            end
            S_TOP_PAD, S_BOT_PAD, S_ROW: begin
                // Pad rows advance every cycle; data rows only on accepted pixels.
                if (state_q != S_ROW || in_valid) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    row_d = row_inc;
                    if (row_inc < R_TOP_END)       state_d = S_TOP_PAD;
                    else if (row_inc < R_DATA_END) state_d = S_ROW;
                    else if (row_inc < R_BOT_END)  state_d = S_BOT_PAD;
                    else                           state_d = S_DONE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            col_d   = '0;
            row_d   = '0;
            gap_d   = '0;
        end
    end

    always_comb begin
        pad_row        = (state_q == S_TOP_PAD) || (state_q == S_BOT_PAD);
        accept         = (state_q == S_ROW) && in_valid;
        in_ready       = (state_q == S_ROW);
        busy           = (state_q != S_IDLE);
        out_valid_d    = pad_row || accept;
        out_data_d     = accept ? in_data : (pad_row ? '0 : out_data_q);
        out_pad_d      = pad_row;
        // One gap cycle early so the delayed row reset clears before the next valid.
        row_complete_d = (state_q == S_GAP) && (gap_q == GAP_RC);
        frame_done_d   = (state_q == S_DONE);
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_pad      = out_pad_q;
    assign row_complete = row_complete_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_line_buffer_row_sequencer.sv
// Self-checking bench: cycle table for the default frame, frame-level reference
// model for strobe order/timing, and hand sequences for stall, abort and reset.
module tb_line_buffer_row_sequencer;

    localparam int X = 3, Y = 3, P = 1, RG = 4, DW = 8, NMAX = 256;
    localparam int PER = X + RG;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0, abort = 1'b0, in_valid = 1'b0, start2 = 1'b0, in_valid2 = 1'b1;
    logic [DW-1:0] in_data = '0, in_data2 = '0;
    logic in_ready, out_valid, out_pad, row_complete, frame_done, busy;
    logic in_ready2, out_valid2, out_pad2, row_complete2, frame_done2, busy2;
    logic [DW-1:0] out_data, out_data2;

    line_buffer_row_sequencer dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_pad(out_pad),
        .row_complete(row_complete), .frame_done(frame_done), .busy(busy)
    );

    line_buffer_row_sequencer #(.PAD(0)) dut_nopad (
        .clk(clk), .rstn(rstn), .start(start2), .abort(abort),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_data(out_data2), .out_pad(out_pad2),
        .row_complete(row_complete2), .frame_done(frame_done2), .busy(busy2)
    );

    int n_checks = 0, n_fail = 0;
    int cyc = 0, acc = 0, acc2 = 0;
    logic [7:0] pix [9];
    logic [7:0] pix2 [9];
    logic rv [2][NMAX], rp [2][NMAX], rrc [2][NMAX], rfd [2][NMAX], rbusy [2][NMAX], rrdy [2][NMAX];
    logic [7:0] rd [2][NMAX];

    typedef struct {
        int         cyc;
        logic       v, pad, rc, fd, busy, rdy;
        logic [7:0] data;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input bit st, input bit vld, input bit ab, input bit st2);
        @(posedge clk); #1;
        start = st; abort = ab; in_valid = vld; start2 = st2;
        in_data = pix[acc % 9]; in_data2 = pix2[acc2 % 9];
        @(negedge clk);
        if (cyc < NMAX) begin
            rv[0][cyc] = out_valid;   rp[0][cyc] = out_pad;   rd[0][cyc] = out_data;
            rrc[0][cyc] = row_complete; rfd[0][cyc] = frame_done;
            rbusy[0][cyc] = busy;     rrdy[0][cyc] = in_ready;
            rv[1][cyc] = out_valid2;  rp[1][cyc] = out_pad2;  rd[1][cyc] = out_data2;
            rrc[1][cyc] = row_complete2; rfd[1][cyc] = frame_done2;
            rbusy[1][cyc] = busy2;    rrdy[1][cyc] = in_ready2;
        end
        if (vld && in_ready) acc++;
        if (in_valid2 && in_ready2) acc2++;
        cyc++;
    endtask

    // Reference: frame = npad zero rows, Y rows of pixels in order, npad zero rows;
    // each row_complete lands RG-1 cycles after the row's last strobe.
    task automatic check_frame(input int d, input string tag, input int t0, input int t1,
                               input int npad, input bit exact, input int base);
        int rows, nstr, row, idx, e_data;
        bit is_pad;
        int sc [$];
        int sd [$];
        int sp [$];
        int rc [$];
        int fd [$];
        rows = Y + 2 * npad;
        nstr = X * rows;
        for (int t = t0; t <= t1; t++) begin
            if (rv[d][t])  begin sc.push_back(t); sd.push_back(int'(rd[d][t])); sp.push_back(int'(rp[d][t])); end
            if (rrc[d][t]) rc.push_back(t);
            if (rfd[d][t]) fd.push_back(t);
        end
        chk($sformatf("%s strobe_count", tag), sc.size(), nstr);
        chk($sformatf("%s rc_count", tag), rc.size(), rows);
        chk($sformatf("%s fd_count", tag), fd.size(), 1);
        for (int k = 0; k < sc.size() && k < nstr; k++) begin
            row    = k / X;
            is_pad = (row < npad) || (row >= npad + Y);
            idx    = (row - npad) * X + (k % X);
            e_data = is_pad ? 0 : int'((d == 0) ? pix[idx] : pix2[idx]);
            chk($sformatf("%s data[%0d]", tag, k), sd[k], e_data);
            chk($sformatf("%s pad[%0d]", tag, k), sp[k], int'(is_pad));
            if (exact) chk($sformatf("%s strobe_cyc[%0d]", tag, k), sc[k], base + 2 + PER * row + (k % X));
        end
        for (int i = 0; i < rc.size() && i < rows; i++) begin
            if ((i + 1) * X - 1 < sc.size())
                chk($sformatf("%s rc_after_row[%0d]", tag, i), rc[i], sc[(i + 1) * X - 1] + RG - 1);
            if ((i + 1) * X < sc.size())
                chk($sformatf("%s idle_before_row[%0d]", tag, i + 1), int'(sc[(i + 1) * X] >= rc[i] + 2), 1);
            if (exact) chk($sformatf("%s rc_cyc[%0d]", tag, i), rc[i], base + PER * (i + 1));
        end
        if (fd.size() == 1 && rc.size() == rows) begin
            chk($sformatf("%s fd_after_rc", tag), fd[0], rc[rows - 1] + 2);
            if (exact) chk($sformatf("%s fd_cyc", tag), fd[0], base + PER * rows + 2);
        end
        if (exact)
            for (int t = t0; t <= t1; t++)
                chk($sformatf("%s busy[%0d]", tag, t), int'(rbusy[d][t]),
                    int'(t >= base + 1 && t < base + PER * rows + 2));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " out_pad"}, out_pad, 0);
        chk({tag, " out_data"}, out_data, 0);
        chk({tag, " row_complete"}, row_complete, 0);
        chk({tag, " frame_done"}, frame_done, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " in_ready"}, in_ready, 0);
    endtask

    initial begin
        int fdc;
        for (int i = 0; i < 9; i++) begin
            pix[i]  = 8'(8'h11 + i);
            pix2[i] = 8'(8'h21 + i);
        end
        // cyc, v, pad, rc, fd, busy, rdy, data
        tbl.push_back('{0,  0,0,0,0,0,0, 8'h00});
        tbl.push_back('{1,  0,0,0,0,1,0, 8'h00});
        tbl.push_back('{2,  1,1,0,0,1,0, 8'h00});
        tbl.push_back('{4,  1,1,0,0,1,0, 8'h00});
        tbl.push_back('{5,  0,0,0,0,1,0, 8'h00});
        tbl.push_back('{7,  0,0,1,0,1,0, 8'h00});
        tbl.push_back('{8,  0,0,0,0,1,1, 8'h00});
        tbl.push_back('{9,  1,0,0,0,1,1, 8'h11});
        tbl.push_back('{10, 1,0,0,0,1,1, 8'h12});
        tbl.push_back('{11, 1,0,0,0,1,0, 8'h13});
        tbl.push_back('{12, 0,0,0,0,1,0, 8'h13});
        tbl.push_back('{14, 0,0,1,0,1,0, 8'h13});
        tbl.push_back('{16, 1,0,0,0,1,1, 8'h14});
        tbl.push_back('{18, 1,0,0,0,1,0, 8'h16});
        tbl.push_back('{23, 1,0,0,0,1,1, 8'h17});
        tbl.push_back('{25, 1,0,0,0,1,0, 8'h19});
        tbl.push_back('{28, 0,0,1,0,1,0, 8'h19});
        tbl.push_back('{30, 1,1,0,0,1,0, 8'h00});
        tbl.push_back('{32, 1,1,0,0,1,0, 8'h00});
        tbl.push_back('{35, 0,0,1,0,1,0, 8'h00});
        tbl.push_back('{36, 0,0,0,0,1,0, 8'h00});
        tbl.push_back('{37, 0,0,0,1,0,0, 8'h00});
        tbl.push_back('{38, 0,0,0,0,0,0, 8'h00});

        #12;
        check_zero_outputs("reset");
        @(negedge clk); rstn = 1'b1;

        // Full frame: cycle table plus frame model.
        cyc = 0; acc = 0;
        for (int c = 0; c < 40; c++) step(c == 0, 1'b1, 1'b0, 1'b0);
        foreach (tbl[i]) begin
            chk($sformatf("tbl%0d out_valid", tbl[i].cyc), rv[0][tbl[i].cyc], tbl[i].v);
            chk($sformatf("tbl%0d out_pad", tbl[i].cyc), rp[0][tbl[i].cyc], tbl[i].pad);
            chk($sformatf("tbl%0d row_complete", tbl[i].cyc), rrc[0][tbl[i].cyc], tbl[i].rc);
            chk($sformatf("tbl%0d frame_done", tbl[i].cyc), rfd[0][tbl[i].cyc], tbl[i].fd);
            chk($sformatf("tbl%0d busy", tbl[i].cyc), rbusy[0][tbl[i].cyc], tbl[i].busy);
            chk($sformatf("tbl%0d in_ready", tbl[i].cyc), rrdy[0][tbl[i].cyc], tbl[i].rdy);
            chk($sformatf("tbl%0d out_data", tbl[i].cyc), rd[0][tbl[i].cyc], tbl[i].data);
        end
        check_frame(0, "full", 0, 39, P, 1'b1, 0);

        // Stall of 5 cycles in the first data row.
        cyc = 0; acc = 0;
        for (int c = 0; c < 45; c++) step(c == 0, !(c >= 9 && c <= 13), 1'b0, 1'b0);
        for (int c = 9; c <= 13; c++) chk($sformatf("stall in_ready[%0d]", c), rrdy[0][c], 1);
        for (int c = 10; c <= 14; c++) chk($sformatf("stall no_strobe[%0d]", c), rv[0][c], 0);
        chk("stall rc_not_early", rrc[0][14], 0);
        chk("stall rc_late", rrc[0][19], 1);
        check_frame(0, "stall", 0, 44, P, 1'b0, 0);

        // PAD=0 instance.
        cyc = 0; acc2 = 0;
        for (int c = 0; c < 28; c++) step(1'b0, 1'b1, 1'b0, c == 0);
        chk("pad0 fd_at_23", rfd[1][23], 1);
        check_frame(1, "pad0", 0, 27, 0, 1'b1, 0);

        // Abort during the second data row, restart two cycles after IDLE.
        cyc = 0; acc = 0;
        for (int c = 0; c < 61; c++) begin
            if (c == 19) acc = 0;
            step(c == 0 || c == 19, 1'b1, c == 16, 1'b0);
        end
        chk("abort busy_next", rbusy[0][17], 0);
        chk("abort ready_next", rrdy[0][18], 0);
        chk("abort cycle_strobe", rv[0][17], 1);
        chk("abort cycle_data", rd[0][17], 8'h15);
        fdc = 0;
        for (int c = 0; c <= 18; c++) fdc += int'(rfd[0][c]);
        chk("abort no_fd", fdc, 0);
        check_frame(0, "restart", 19, 60, P, 1'b1, 19);

        // Reset during the bottom pad row, then a clean frame with ignored starts.
        cyc = 0; acc = 0;
        for (int c = 0; c < 30; c++) step(c == 0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0; rstn = 1'b0;
        #1;
        check_zero_outputs("midreset");
        @(negedge clk); rstn = 1'b1;
        cyc = 0; acc = 0;
        for (int c = 0; c < 46; c++) step(c == 0 || c == 10 || c == 20, 1'b1, 1'b0, 1'b0);
        check_frame(0, "after_reset", 0, 45, P, 1'b1, 0);

        // Random valid patterns, random pixels, random starts while busy.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 9; i++) pix[i] = 8'($urandom_range(0, 255));
            cyc = 0; acc = 0;
            for (int c = 0; c < 150; c++)
                step(c == 0 || (c <= 30 && $urandom_range(0, 7) == 0),
                     $urandom_range(0, 3) != 0, 1'b0, 1'b0);
            check_frame(0, $sformatf("rand%0d", f), 0, 149, P, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
